p_s_ctrl: RTL and testbench

- Sequencer for the FFT output parallel-to-serial stage. Sits between the last butterfly stage and the serial output port.
- Accepts 4 parallel beats of 4 samples each (one 16-point frame) from upstream under a valid/ready handshake, and drives the register-file write strobes.
- Then walks the 16 stored samples out in natural order under a downstream valid/ready handshake.
- Generates address and control only; carries no sample data.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/p_s_ctrl_if.sv | 42 ++++
 rtl/ps_bank_tracker.sv | 46 ++++
 rtl/p_s_ctrl.sv | 131 +++++++++++++
 tb/tb_p_s_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and sizing for the FFT parallel-to-serial output sequencer.
package fft_pkg;

  localparam int unsigned PS_LANES  = 4;
  localparam int unsigned PS_BEATS  = 4;
  localparam int unsigned PS_POINTS = PS_LANES * PS_BEATS;
  localparam int unsigned PS_FCNT_W = 8;

  // Index width that never collapses to zero bits for a degenerate count of 1.
  function automatic int unsigned ps_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned PS_LANE_W = ps_idx_w(PS_LANES);
  localparam int unsigned PS_BEAT_W = ps_idx_w(PS_BEATS);
  localparam int unsigned PS_PTR_W  = ps_idx_w(PS_POINTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } ps_state_t;

endpackage

// File: rtl/p_s_ctrl_if.sv
// Load/drain handshake and register-file addressing bundle of the p_s_ctrl sequencer.
interface p_s_ctrl_if
  import fft_pkg::*;
#(
  parameter int unsigned N_LANES = PS_LANES,
  parameter int unsigned N_BEATS = PS_BEATS,
  parameter int unsigned FCNT_W  = PS_FCNT_W
) ();

  localparam int unsigned LANE_W = ps_idx_w(N_LANES);
  localparam int unsigned BEAT_W = ps_idx_w(N_BEATS);

  logic              in_valid;
  logic              in_ready;
  logic              ld_en;
  logic [BEAT_W-1:0] ld_beat;
  logic              ld_bank;
  logic              out_valid;
  logic              out_ready;
  logic [BEAT_W-1:0] rd_beat;
  logic [LANE_W-1:0] rd_lane;
  logic              rd_bank;
  logic              out_first;
  logic              out_last;
  logic [FCNT_W-1:0] frame_cnt;
  logic              busy;

  modport slave (
    input  in_valid, out_ready,
    output in_ready, ld_en, ld_beat, ld_bank,
    output out_valid, rd_beat, rd_lane, rd_bank, out_first, out_last,
    output frame_cnt, busy
  );

  modport master (
    output in_valid, out_ready,
    input  in_ready, ld_en, ld_beat, ld_bank,
    input  out_valid, rd_beat, rd_lane, rd_bank, out_first, out_last,
    input  frame_cnt, busy
  );

endinterface

// File: rtl/ps_bank_tracker.sv
// Two-bank full flags with independent write/read bank toggles for ping-pong operation.
module ps_bank_tracker (
  input  logic clk,
  input  logic rst,
  input  logic i_wr_done,
  input  logic i_rd_done,
  output logic o_wr_bank,
  output logic o_rd_bank,
  output logic o_wr_full_n_c,
  output logic o_rd_full_n_c
);

  logic [1:0] r_full;
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [1:0] w_full_n;
  logic       w_wr_bank_n;
  logic       w_rd_bank_n;

  // A finishing write and a finishing read always target different banks.
  always_comb begin
    w_full_n = r_full;
    if (i_wr_done) w_full_n[r_wr_bank] = 1'b1;
    if (i_rd_done) w_full_n[r_rd_bank] = 1'b0;
    w_wr_bank_n = r_wr_bank ^ i_wr_done;
    w_rd_bank_n = r_rd_bank ^ i_rd_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_full    <= w_full_n;
      r_wr_bank <= w_wr_bank_n;
      r_rd_bank <= w_rd_bank_n;
    end
  end

  assign o_wr_bank     = r_wr_bank;
  assign o_rd_bank     = r_rd_bank;
  assign o_wr_full_n_c = w_full_n[w_wr_bank_n];
  assign o_rd_full_n_c = w_full_n[w_rd_bank_n];

endmodule

// File: rtl/p_s_ctrl.sv
// Parallel-to-serial sequencer: loads N_BEATS beats, then walks all samples out in order.
// Define PS_CTRL_PINGPONG_EN for two-bank overlapped load/drain.
module p_s_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N_LANES = PS_LANES,
  parameter int unsigned N_BEATS = PS_BEATS,
  parameter int unsigned FCNT_W  = PS_FCNT_W
) (
  input  logic          clk,
  input  logic          rst,
  p_s_ctrl_if.slave     bus
);

  localparam int unsigned LANE_W   = ps_idx_w(N_LANES);
  localparam int unsigned BEAT_W   = ps_idx_w(N_BEATS);
  localparam int unsigned PTR_W    = LANE_W + BEAT_W;
  localparam int unsigned N_POINTS = N_LANES * N_BEATS;

  ps_state_t         r_state;
  ps_state_t         w_state_n;
  logic [BEAT_W-1:0] r_wr_ptr;
  logic [BEAT_W-1:0] w_wr_ptr_n;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  w_rd_ptr_n;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_first;
  logic              r_out_last;
  logic              r_busy;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic w_acc;
  logic w_wr_done;
  logic w_xfer;
  logic w_rd_done;
  logic w_wr_bank;
  logic w_rd_bank;
  logic w_wr_full_n;
  logic w_rd_full_n;

  always_comb begin
    w_acc      = bus.in_valid & r_in_ready;
    w_wr_done  = w_acc & (r_wr_ptr == BEAT_W'(N_BEATS - 1));
    w_xfer     = r_out_valid & bus.out_ready;
    w_rd_done  = w_xfer & (r_rd_ptr == PTR_W'(N_POINTS - 1));
    w_wr_ptr_n = w_acc  ? r_wr_ptr + 1'b1 : r_wr_ptr;
    w_rd_ptr_n = w_xfer ? r_rd_ptr + 1'b1 : r_rd_ptr;
  end

`ifdef PS_CTRL_PINGPONG_EN
  ps_bank_tracker u_bank_tracker (
    .clk           (clk),
    .rst           (rst),
    .i_wr_done     (w_wr_done),
    .i_rd_done     (w_rd_done),
    .o_wr_bank     (w_wr_bank),
    .o_rd_bank     (w_rd_bank),
    .o_wr_full_n_c (w_wr_full_n),
    .o_rd_full_n_c (w_rd_full_n)
  );
`else
  logic r_full;
  logic w_full_n;

  // Single bank: loading is blocked while draining, so done events never coincide.
  assign w_full_n = w_wr_done | (r_full & ~w_rd_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_full <= 1'b0;
    else     r_full <= w_full_n;
  end

  assign w_wr_bank   = 1'b0;
  assign w_rd_bank   = 1'b0;
  assign w_wr_full_n = w_full_n;
  assign w_rd_full_n = w_full_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  // DRAIN persists while any bank is full; otherwise a partial load means LOAD.
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:    if (w_acc)        w_state_n = w_rd_full_n ? DRAIN : LOAD;
      LOAD:    if (w_rd_full_n)  w_state_n = DRAIN;
      DRAIN:   if (!w_rd_full_n) w_state_n = (w_wr_ptr_n != '0) ? LOAD : IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_n;
      r_rd_ptr    <= w_rd_ptr_n;
      r_in_ready  <= ~w_wr_full_n;
      r_out_valid <= w_rd_full_n;
      r_out_first <= w_rd_full_n & (w_rd_ptr_n == '0);
      r_out_last  <= w_rd_full_n & (w_rd_ptr_n == PTR_W'(N_POINTS - 1));
      r_busy      <= (w_state_n != IDLE);
      if (w_rd_done) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.ld_en     = w_acc;
  assign bus.ld_beat   = r_wr_ptr;
  assign bus.ld_bank   = w_wr_bank;
  assign bus.out_valid = r_out_valid;
  assign bus.rd_lane   = r_rd_ptr[LANE_W-1:0];
  assign bus.rd_beat   = r_rd_ptr[PTR_W-1:LANE_W];
  assign bus.rd_bank   = w_rd_bank;
  assign bus.out_first = r_out_first;
  assign bus.out_last  = r_out_last;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_p_s_ctrl.sv
// Directed self-checking bench for p_s_ctrl; frame-level reference model for longer runs.
module tb_p_s_ctrl;

`ifdef PS_CTRL_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic clk;
  logic rst;

  p_s_ctrl_if bus ();

  p_s_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_wr;
  int         m_rd;
  int         m_nfull;
  bit         m_wb;
  bit         m_rb;
  logic [7:0] m_fcnt;

  // {in_ready, ld_en, ld_beat, ld_bank, out_valid, rd_beat, rd_lane, rd_bank,
  //  out_first, out_last, frame_cnt, busy}
  function automatic logic [21:0] obs_vec();
    return {bus.in_ready, bus.ld_en, bus.ld_beat, bus.ld_bank, bus.out_valid,
            bus.rd_beat, bus.rd_lane, bus.rd_bank, bus.out_first, bus.out_last,
            bus.frame_cnt, bus.busy};
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_nfull = 0; m_wb = 1'b0; m_rb = 1'b0; m_fcnt = 8'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  task automatic run_model(input string name, input int n_frames, input int n_cyc,
                           input logic [31:0] iv_pat, input logic [31:0] or_pat);
    int frames = 0;
    logic [21:0] exp_v;
    logic [21:0] got_v;
    bit ir, le, ov, wr_done, rd_done;
    for (int c = 0; c < n_cyc; c++) begin
      if (n_frames != 0 && frames >= n_frames) break;
      bus.in_valid  = iv_pat[c % 32];
      bus.out_ready = or_pat[c % 32];
      #1;
      ir = (m_nfull < NB);
      ov = (m_nfull > 0);
      le = bus.in_valid && ir;
      exp_v = {ir, le, 2'(m_wr), m_wb, ov, 2'(m_rd >> 2), 2'(m_rd & 3), m_rb,
               1'(ov && m_rd == 0), 1'(ov && m_rd == 15), m_fcnt,
               1'(m_wr != 0 || m_nfull > 0)};
      got_v = obs_vec();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got_v, exp_v);
      end
      wr_done = le && (m_wr == 3);
      rd_done = ov && bus.out_ready && (m_rd == 15);
      if (le) m_wr = (m_wr + 1) % 4;
      if (ov && bus.out_ready) m_rd = (m_rd + 1) % 16;
      if (wr_done) begin
        m_nfull++;
        if (NB == 2) m_wb = ~m_wb;
      end
      if (rd_done) begin
        m_nfull--;
        if (NB == 2) m_rb = ~m_rb;
        m_fcnt = m_fcnt + 8'd1;
        frames++;
      end
      @(negedge clk);
    end
    if (n_frames != 0) begin
      n_tests++;
      if (frames < n_frames) begin
        n_fail++;
        $display("FAIL %s_timeout frames=%0d required=%0d", name, frames, n_frames);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] got_v;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    got_v = obs_vec();
    n_tests++;
    if (got_v !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_idle got=%h exp=%h", got_v, 22'h0);
    end
    bus.in_valid = 1'b1;
    #1;
    got_v = obs_vec();
    n_tests++;
    if (got_v !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_no_ld got=%h exp=%h", got_v, 22'h0);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    got_v = obs_vec();
    n_tests++;
    if (got_v !== {1'b1, 21'h0}) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", got_v, {1'b1, 21'h0});
    end
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic [21:0] exp_v;
    logic [21:0] got_v;
    bit pp;
    pp = (NB == 2);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      exp_v = {1'b1, 1'b1, 2'(k), 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'(k != 0)};
      got_v = obs_vec();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL basic_load beat=%0d got=%h exp=%h", k, got_v, exp_v);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int p = 0; p < 16; p++) begin
      #1;
      exp_v = {pp, 1'b0, 2'd0, pp, 1'b1, 2'(p >> 2), 2'(p & 3), 1'b0,
               1'(p == 0), 1'(p == 15), 8'd0, 1'b1};
      got_v = obs_vec();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL basic_drain sample=%0d got=%h exp=%h", p, got_v, exp_v);
      end
      @(negedge clk);
    end
    #1;
    exp_v = {1'b1, 1'b0, 2'd0, pp, 1'b0, 2'd0, 2'd0, pp, 1'b0, 1'b0, 8'd1, 1'b0};
    got_v = obs_vec();
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL basic_done got=%h exp=%h", got_v, exp_v);
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stall();
    do_reset();
    run_model("stall_a", 2, 400, 32'hB5D3_6E9B, 32'h5A3C_96E1);
    run_model("stall_b", 1, 400, 32'h9249_2492, 32'hCC33_A5A5);
  endtask

  task automatic test_reset_midframe();
    logic [21:0] got_v;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      #1;
      n_tests++;
      if (bus.ld_en !== 1'b1 || bus.ld_beat !== 2'(k)) begin
        n_fail++;
        $display("FAIL midrst_load beat=%0d got_en=%b got_beat=%0d", k, bus.ld_en, bus.ld_beat);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    got_v = obs_vec();
    n_tests++;
    if (got_v !== 22'h0) begin
      n_fail++;
      $display("FAIL midrst_async got=%h exp=%h", got_v, 22'h0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    run_model("midrst_frame", 1, 200, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_frame_wrap();
    do_reset();
    run_model("wrap", 256, 256 * 24 + 64, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    n_tests++;
    if (bus.frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_frame_cnt got=%0d exp=0", bus.frame_cnt);
    end
    @(negedge clk);
  endtask

`ifdef PS_CTRL_PINGPONG_EN
  task automatic test_pingpong_stream();
    do_reset();
    run_model("pp_stream", 4, 200, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_pingpong_backpressure();
    do_reset();
    run_model("pp_hold", 0, 40, 32'hFFFF_FFFF, 32'h0000_0000);
    run_model("pp_flush", 2, 200, 32'h0000_0000, 32'hFFFF_FFFF);
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    test_reset();
    test_basic_frame();
    test_stall();
    test_reset_midframe();
    test_frame_wrap();
`ifdef PS_CTRL_PINGPONG_EN
    test_pingpong_stream();
    test_pingpong_backpressure();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
